// File: rtl/decode_exec_skid.sv
// Decode->Execute pipeline register with a two-entry skid buffer and flush.
// Optional DECODE_EXEC_STATS_EN adds stall/bubble/flush counters.
module decode_exec_skid #(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_imm,
  input  logic [31:0]       in_opa,
  input  logic [31:0]       in_opb,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_imm,
  output logic [31:0]       out_opa,
  output logic [31:0]       out_opb,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef DECODE_EXEC_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  localparam int unsigned PayloadW = 128 + REG_AW + CTRL_W;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e              state_q, state_d;
  logic [PayloadW-1:0] m_q, m_d, s_q, s_d;
  logic [PayloadW-1:0] in_payload;
  logic                acc, pop;

  assign in_payload = {in_pc, in_imm, in_opa, in_opb, in_rd, in_ctrl};
  assign {out_pc, out_imm, out_opa, out_opb, out_rd, out_ctrl} = m_q;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (acc) begin
            m_d     = in_payload;
            state_d = StOne;
          end
        end
        StOne: begin
          if (acc && pop) begin
            m_d = in_payload;
          end else if (acc) begin
            s_d     = in_payload;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            m_d     = s_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

`ifdef DECODE_EXEC_STATS_EN
  logic [31:0] stall_q, bubble_q;
  logic [15:0] flush_q;
  logic        flush_drops;

  // A popped head in ONE is consumed, not discarded; FULL always loses S.
  assign flush_drops = flush & (acc | (state_q == StFull) | ((state_q == StOne) & ~out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q  <= '0;
      bubble_q <= '0;
      flush_q  <= '0;
    end else begin
      if (in_valid && !in_ready) stall_q <= stall_q + 32'd1;
      if (!out_valid && out_ready) bubble_q <= bubble_q + 32'd1;
      if (flush_drops) flush_q <= flush_q + 16'd1;
    end
  end

  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;
  assign flush_cnt  = flush_q;
`endif

endmodule
